// File: rtl/apb_pkg.sv
// Shared APB definitions used by the completer, the bus interface and the
// verification components that observe it.
package apb_pkg;
   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;
endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x 32-bit word storage: synchronous write, synchronous bulk clear,
// combinational read so the completer can capture read data at its setup edge.
module apb_mem_array
   import apb_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [APB_DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [APB_DATA_W-1:0] rd_data
);

   logic [APB_DATA_W-1:0] mem [DEPTH];

   // Clear has priority so a reset during a completing write leaves the word zeroed.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer fronting a word-addressed register bank, with programmable
// PREADY wait states and PSLVERR on misaligned or out-of-window accesses.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter int                    DEPTH       = 256,
   parameter int                    WAIT_CYCLES = 0
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSELx,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [APB_ADDR_W-1:0] PADDR,
   input  logic [APB_DATA_W-1:0] PWDATA,
   output logic [APB_DATA_W-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   localparam int                  IDX_W     = $clog2(DEPTH);
   localparam int                  OFS_W     = APB_ADDR_W + 1;
   localparam logic [OFS_W-1:0]    SPAN      = OFS_W'(4 * DEPTH);
   localparam logic [3:0]          WAIT_INIT = 4'(WAIT_CYCLES);
   localparam logic                NO_WAIT   = (WAIT_CYCLES == 0);

   apb_state_e            state;
   apb_state_e            state_nxt;
   logic [3:0]            cnt;
   logic [3:0]            cnt_nxt;
   logic [APB_DATA_W-1:0] prdata_nxt;
   logic                  pready_nxt;
   logic                  pslverr_nxt;
   logic                  wr_en;
   logic                  err;
   logic [OFS_W-1:0]      offset;
   logic [IDX_W-1:0]      idx;
   logic [APB_DATA_W-1:0] rd_data;
   logic                  clear;

   // One extra bit catches the borrow: addresses below BASE_ADDR wrap to a huge
   // offset and fail the same upper-bound compare as addresses past the window.
   assign offset = {1'b0, PADDR} - {1'b0, BASE_ADDR};
   assign err    = (PADDR[1:0] != 2'b00) | (offset >= SPAN);
   assign idx    = offset[IDX_W+1:2];
   assign clear  = ~PRESETn;

   apb_mem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk     (PCLK),
      .clear   (clear),
      .wr_en   (wr_en),
      .wr_idx  (idx),
      .wr_data (PWDATA),
      .rd_idx  (idx),
      .rd_data (rd_data)
   );

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state   <= IDLE;
         cnt     <= '0;
         PRDATA  <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         PRDATA  <= prdata_nxt;
         PREADY  <= pready_nxt;
         PSLVERR <= pslverr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (PSELx && !PENABLE) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (!PSELx || PREADY) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cnt_nxt     = cnt;
      prdata_nxt  = PRDATA;
      pready_nxt  = PREADY;
      pslverr_nxt = PSLVERR;
      wr_en       = 1'b0;
      case (state)
         IDLE: begin
            // A lone PENABLE without a setup phase falls through and holds outputs.
            if (PSELx && !PENABLE) begin
               cnt_nxt     = WAIT_INIT;
               pready_nxt  = NO_WAIT;
               pslverr_nxt = err & NO_WAIT;
               if (!PWRITE) begin
                  prdata_nxt = err ? '0 : rd_data;
               end
            end
         end
         ACCESS: begin
            if (!PSELx) begin
               pready_nxt  = 1'b0;
               pslverr_nxt = 1'b0;
            end else if (PREADY) begin
               wr_en       = PWRITE & PENABLE & ~err;
               pready_nxt  = 1'b0;
               pslverr_nxt = 1'b0;
            end else begin
               cnt_nxt     = cnt - 4'd1;
               pready_nxt  = (cnt == 4'd1);
               pslverr_nxt = err & (cnt == 4'd1);
            end
         end
         default: begin
            pready_nxt  = 1'b0;
            pslverr_nxt = 1'b0;
         end
      endcase
   end

endmodule
